rv_alu: RTL and testbench

Registered 32-bit integer ALU for the RV32I execute stage. Computes add, sub, shifts, signed/unsigned set-less-than and bitwise logic on two 32-bit operands selected by a 4-bit control code. The result and zero flag are registered, so results appear one clock after operands are presented. It is driven by the decode/control unit and feeds the branch logic and writeback.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_shifter.sv | 27 ++
 rtl/rv_alu.sv | 72 +++++++
 tb/tb_rv_alu.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the RV32I execute-stage ALU.
package alu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b1000,
      OP_SLL  = 4'b0001,
      OP_SLT  = 4'b0010,
      OP_SLTU = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_SRL  = 4'b0101,
      OP_SRA  = 4'b1101,
      OP_OR   = 4'b0110,
      OP_AND  = 4'b0111
   } alu_op_t;

   function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
      logic [XLEN-1:0] r;
      for (int i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
      return r;
   endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational 5-stage barrel shifter for sll/srl/sra.
// Left shifts reuse the right-shift stages by bit-reversing the operand in and out.
module alu_shifter
   import alu_pkg::*;
(
   input  logic [XLEN-1:0] operand,
   input  logic [4:0]      shamt,
   input  logic            right,
   input  logic            arith,
   output logic [XLEN-1:0] result
);

   logic            fill;
   logic [XLEN-1:0] st0, st1, st2, st3, st4, st5;

   always_comb begin
      fill = arith & right & operand[XLEN-1];
      st0  = right ? operand : bit_reverse(operand);
      st1  = shamt[0] ? {fill, st0[XLEN-1:1]}          : st0;
      st2  = shamt[1] ? {{2{fill}}, st1[XLEN-1:2]}     : st1;
      st3  = shamt[2] ? {{4{fill}}, st2[XLEN-1:4]}     : st2;
      st4  = shamt[3] ? {{8{fill}}, st3[XLEN-1:8]}     : st3;
      st5  = shamt[4] ? {{16{fill}}, st4[XLEN-1:16]}   : st4;
      result = right ? st5 : bit_reverse(st5);
   end

endmodule

// File: rtl/rv_alu.sv
// Registered RV32I ALU: one-cycle latency result with valid strobe.
// Optional registered zero flag is built when ALU_ZERO_FLAG_EN is defined.
module rv_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ctrl,
   input  logic             valid_in,
   output logic [WIDTH-1:0] res,
`ifdef ALU_ZERO_FLAG_EN
   output logic             zero,
`endif
   output logic             valid_out
);

   logic [WIDTH-1:0] addsub;
   logic [WIDTH-1:0] shift_res;
   logic [WIDTH-1:0] res_nxt;
   logic             lt_s, lt_u;

   // ctrl[3] selects subtract (two's complement via invert + carry-in)
   assign addsub = A + (B ^ {WIDTH{ctrl[3]}}) + WIDTH'(ctrl[3]);
   assign lt_s   = $signed(A) < $signed(B);
   assign lt_u   = A < B;

   alu_shifter u_shifter (
      .operand (A),
      .shamt   (B[4:0]),
      .right   (ctrl[2]),
      .arith   (ctrl[3]),
      .result  (shift_res)
   );

   always_comb begin
      res_nxt = '0;
      case (ctrl)
         OP_ADD, OP_SUB:  res_nxt = addsub;
         OP_SLL, OP_SRL,
         OP_SRA:          res_nxt = shift_res;
         OP_SLT:          res_nxt = WIDTH'(lt_s);
         OP_SLTU:         res_nxt = WIDTH'(lt_u);
         OP_XOR:          res_nxt = A ^ B;
         OP_OR:           res_nxt = A | B;
         OP_AND:          res_nxt = A & B;
         default:         res_nxt = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res       <= '0;
         valid_out <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
         zero      <= 1'b1;
`endif
      end else begin
         valid_out <= valid_in;
         if (valid_in) begin
            res  <= res_nxt;
`ifdef ALU_ZERO_FLAG_EN
            zero <= (res_nxt == '0);
`endif
         end
      end
   end

endmodule

// File: tb/tb_rv_alu.sv
// Self-checking bench for rv_alu: directed steps plus a random back-to-back burst,
// with expected results queued at issue and popped when valid_out appears.
module tb_rv_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a_in, b_in;
   logic [3:0]  ctrl_in;
   logic        valid_in;
   logic [31:0] res;
   logic        valid_out;
`ifdef ALU_ZERO_FLAG_EN
   logic        zero;
`endif

   int          passed = 0;
   int          total  = 0;
   logic [31:0] exp_q[$];
   logic [31:0] held  = '0;

   always #5 clk = ~clk;

   rv_alu dut (
      .clk       (clk),
      .rst       (rst),
      .A         (a_in),
      .B         (b_in),
      .ctrl      (ctrl_in),
      .valid_in  (valid_in),
      .res       (res),
`ifdef ALU_ZERO_FLAG_EN
      .zero      (zero),
`endif
      .valid_out (valid_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
      logic [4:0] sh;
      sh = b[4:0];
      case (c)
         4'b0000: return a + b;
         4'b1000: return a - b;
         4'b0001: return a << sh;
         4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b0011: return (a < b) ? 32'd1 : 32'd0;
         4'b0100: return a ^ b;
         4'b0101: return a >> sh;
         4'b1101: return $unsigned($signed(a) >>> sh);
         4'b0110: return a | b;
         4'b0111: return a & b;
         default: return 32'd0;
      endcase
   endfunction

   // One clock: drive inputs, queue expectation, then check outputs after the edge.
   task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic [31:0] er, input string tag);
      logic [31:0] got;
      a_in = a; b_in = b; ctrl_in = c; valid_in = v;
      if (v && !rst) exp_q.push_back(er);
      @(posedge clk);
      #1;
      if (rst) begin
         held = '0;
         exp_q.delete();
         chk({tag, "_vout"}, {31'b0, valid_out}, 32'd0);
         chk({tag, "_res"}, res, 32'd0);
      end else begin
         chk({tag, "_vout"}, {31'b0, valid_out}, {31'b0, v});
         if (valid_out === 1'b1) begin
            chk({tag, "_qsize"}, (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
               got  = exp_q.pop_front();
               held = got;
            end
         end
         chk({tag, "_res"}, res, held);
      end
`ifdef ALU_ZERO_FLAG_EN
      chk({tag, "_zero"}, {31'b0, zero}, {31'b0, (held == 32'd0)});
`endif
   endtask

   initial begin
      rst = 1'b1; a_in = '0; b_in = '0; ctrl_in = '0; valid_in = 1'b0;
      cycle(1'b1, 32'd1, 32'd1, 4'b0000, 32'd0, "rst1");
      cycle(1'b0, 32'd0, 32'd0, 4'b0000, 32'd0, "rst2");
      rst = 1'b0;

      cycle(1'b1, 32'd31, 32'd32, 4'b0000, 32'd63, "first_add");
      cycle(1'b1, 32'd5, 32'hFFFF_FFFE, 4'b0000, 32'd3, "add_neg");
      cycle(1'b1, 32'd4, 32'd2, 4'b1000, 32'd2, "sub");
      cycle(1'b1, 32'd4, 32'hFFFF_FFFE, 4'b1000, 32'd6, "sub_neg");
      cycle(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0000, 32'd0, "add_wrap");

      cycle(1'b1, 32'd3, 32'd1, 4'b0010, 32'd0, "slt_3_1");
      cycle(1'b1, 32'd1, 32'd3, 4'b0010, 32'd1, "slt_1_3");
      cycle(1'b1, 32'd1, 32'hFFFF_FFFD, 4'b0010, 32'd0, "slt_1_m3");
      cycle(1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 4'b0010, 32'd0, "slt_m3_m5");
      cycle(1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 4'b0010, 32'd1, "slt_m5_m3");
      cycle(1'b1, 32'hC000_0000, 32'd0, 4'b0011, 32'd0, "sltu_big_0");
      cycle(1'b1, 32'd0, 32'hC000_0000, 4'b0011, 32'd1, "sltu_0_big");

      cycle(1'b1, 32'h8000_0001, 32'd4, 4'b0001, 32'h0000_0010, "sll");
      cycle(1'b1, 32'h8000_0001, 32'd4, 4'b0101, 32'h0800_0000, "srl");
      cycle(1'b1, 32'h8000_0001, 32'd4, 4'b1101, 32'hF800_0000, "sra");
      cycle(1'b1, 32'h8000_0001, 32'h0000_0024, 4'b0001, 32'h0000_0010, "sll_bhi");

      cycle(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0100, 32'h0FF0_0FF0, "xor");
      cycle(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0110, 32'hFFF0_FFF0, "or");
      cycle(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0111, 32'hF000_F000, "and");
      cycle(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b1111, 32'd0, "illegal_f");
      cycle(1'b1, 32'd9, 32'd9, 4'b0000, 32'd18, "pre_hold");
      cycle(1'b0, 32'd1, 32'd2, 4'b0000, 32'd0, "hold1");
      cycle(1'b0, 32'd7, 32'd7, 4'b0111, 32'd0, "hold2");

      // Reset in the middle of a stream drops the in-flight op.
      cycle(1'b1, 32'd100, 32'd1, 4'b0000, 32'd101, "pre_rst");
      rst = 1'b1;
      cycle(1'b1, 32'd50, 32'd50, 4'b0000, 32'd0, "rst_mid");
      rst = 1'b0;
      cycle(1'b0, 32'd3, 32'd3, 4'b0000, 32'd0, "post_rst_idle");
      cycle(1'b1, 32'd7, 32'd8, 4'b0000, 32'd15, "post_rst_add");

      for (int i = 0; i < 40; i++) begin
         logic [31:0] ra, rb;
         logic [3:0]  rc;
         logic        rv;
         ra = $urandom;
         rb = $urandom;
         rc = 4'($urandom_range(0, 15));
         rv = ($urandom_range(0, 7) != 0);
         cycle(rv, ra, rb, rc, model(ra, rb, rc), $sformatf("rand%0d_op%0h", i, rc));
      end

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
